reg_file_wr_arbiter: RTL and testbench

- Sequences and shares the single write port of the 32x8 dual-read register file.
- Arbitrates between three write sources, highest priority first:
  - a hardware clear sequencer that zeroes all registers;
  - the CPU writeback path (zero-latency, stallable);
  - a debug write port with a req/ack handshake and starvation guard.
- Sits between the control unit / debug interface and the register file write inputs (DIN, ADRX, RF_WR). Read ports are untouched.

---
 rtl/reg_file_wr_arbiter.sv | 152 +++++++++++++++
 tb/tb_reg_file_wr_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_wr_arbiter.sv
// reg_file_wr_arbiter: owns the single write port of the register file and shares it between
// three sources, highest priority first:
//   1. the hardware clear sequencer, which writes zero to every register in turn;
//   2. the CPU writeback path, which has zero latency and can be stalled;
//   3. the debug write port, which uses a req/ack handshake and has a starvation guard.
//
// Ports:
//   CLK, RST_N                   clock (rising edge), asynchronous active-low reset
//   CLR_REQ / CLR_BUSY / CLR_DONE   start clear / clear in progress / one-cycle done pulse
//   CPU_WR, CPU_ADR, CPU_DIN     CPU write request; CPU_STALL means it was not accepted
//   DBG_WR_REQ, DBG_ADR, DBG_DIN debug write request; DBG_WR_ACK means it was issued
//   RF_WR, RF_ADRX, RF_DIN       register file write port
//
// Optional feature (macro RF_R0_ZERO_EN): CPU and debug writes to address 0 are accepted but
// suppressed, so R0 always reads 0. Clear-sequencer writes to address 0 are unaffected.
module reg_file_wr_arbiter #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CLR_REQ,
  output logic              CLR_BUSY,
  output logic              CLR_DONE,
  input  logic              CPU_WR,
  input  logic [ADDR_W-1:0] CPU_ADR,
  input  logic [DATA_W-1:0] CPU_DIN,
  output logic              CPU_STALL,
  input  logic              DBG_WR_REQ,
  input  logic [ADDR_W-1:0] DBG_ADR,
  input  logic [DATA_W-1:0] DBG_DIN,
  output logic              DBG_WR_ACK,
  output logic              RF_WR,
  output logic [ADDR_W-1:0] RF_ADRX,
  output logic [DATA_W-1:0] RF_DIN
);

  localparam int unsigned CntW = $clog2(STARVE_LIM + 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_adr_q, clr_adr_d;
  logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
  logic              clr_done_q, clr_done_d;

  logic              dbg_force;
  logic              dbg_win;
  logic              cpu_win;
  logic [ADDR_W-1:0] sel_adr;
  logic [DATA_W-1:0] sel_din;
  logic              r0_block;

  // Debug has waited long enough that it now preempts the CPU.
  assign dbg_force = (wait_cnt_q >= CntW'(STARVE_LIM));

  // Winner among CPU and debug. This only takes effect while the block is in IDLE.
  assign dbg_win = DBG_WR_REQ && (dbg_force || !CPU_WR);
  assign cpu_win = CPU_WR && !dbg_win;
  assign sel_adr = dbg_win ? DBG_ADR : CPU_ADR;
  assign sel_din = dbg_win ? DBG_DIN : CPU_DIN;

`ifdef RF_R0_ZERO_EN
  assign r0_block = (sel_adr == '0);
`else
  assign r0_block = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      clr_adr_q  <= '0;
      wait_cnt_q <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_adr_q  <= clr_adr_d;
      wait_cnt_q <= wait_cnt_d;
      clr_done_q <= clr_done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    clr_adr_d  = clr_adr_q;
    clr_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (CLR_REQ) begin
          state_d   = StClear;
          clr_adr_d = '0;
        end
      end
      StClear: begin
        if (clr_adr_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d    = StIdle;
          clr_adr_d  = '0;
          clr_done_d = 1'b1;
        end else begin
          clr_adr_d = clr_adr_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // The counter keeps running during CLEAR, so a debug request that is left pending through
    // a long clear wins the first IDLE cycle afterwards.
    if (DBG_WR_ACK || !DBG_WR_REQ) begin
      wait_cnt_d = '0;
    end else if (!dbg_force) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // Output logic.
  always_comb begin
    RF_WR      = 1'b0;
    RF_ADRX    = '0;
    RF_DIN     = '0;
    CPU_STALL  = 1'b0;
    DBG_WR_ACK = 1'b0;
    CLR_BUSY   = 1'b0;
    unique case (state_q)
      StClear: begin
        CLR_BUSY  = 1'b1;
        RF_WR     = 1'b1;
        RF_ADRX   = clr_adr_q;
        CPU_STALL = CPU_WR;
      end
      StIdle: begin
        DBG_WR_ACK = dbg_win;
        CPU_STALL  = CPU_WR && dbg_win;
        // The requester is still acknowledged when the write itself is suppressed.
        if ((dbg_win || cpu_win) && !r0_block) begin
          RF_WR   = 1'b1;
          RF_ADRX = sel_adr;
          RF_DIN  = sel_din;
        end
      end
      default: ;
    endcase
  end

  assign CLR_DONE = clr_done_q;

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
module tb_reg_file_wr_arbiter;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       CLR_REQ, CLR_BUSY, CLR_DONE;
  logic       CPU_WR, CPU_STALL;
  logic [4:0] CPU_ADR;
  logic [7:0] CPU_DIN;
  logic       DBG_WR_REQ, DBG_WR_ACK;
  logic [4:0] DBG_ADR;
  logic [7:0] DBG_DIN;
  logic       RF_WR;
  logic [4:0] RF_ADRX;
  logic [7:0] RF_DIN;

`ifdef RF_R0_ZERO_EN
  localparam bit R0Zero = 1'b1;
`else
  localparam bit R0Zero = 1'b0;
`endif

  typedef struct packed {
    logic       clr;
    logic       cwr;
    logic [4:0] cadr;
    logic [7:0] cdin;
    logic       dreq;
    logic [4:0] dadr;
    logic [7:0] ddin;
  } in_t;

  typedef struct packed {
    logic       wr;
    logic [4:0] adr;
    logic [7:0] din;
    logic       stall;
    logic       ack;
    logic       busy;
    logic       done;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  int   n_checks = 0;
  int   n_errors = 0;
  out_t exp_q[$];
  vec_t tbl[12];

  reg_file_wr_arbiter dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .CLR_REQ    (CLR_REQ),
    .CLR_BUSY   (CLR_BUSY),
    .CLR_DONE   (CLR_DONE),
    .CPU_WR     (CPU_WR),
    .CPU_ADR    (CPU_ADR),
    .CPU_DIN    (CPU_DIN),
    .CPU_STALL  (CPU_STALL),
    .DBG_WR_REQ (DBG_WR_REQ),
    .DBG_ADR    (DBG_ADR),
    .DBG_DIN    (DBG_DIN),
    .DBG_WR_ACK (DBG_WR_ACK),
    .RF_WR      (RF_WR),
    .RF_ADRX    (RF_ADRX),
    .RF_DIN     (RF_DIN)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "timeout");
  end

  function automatic in_t mi(input logic clr, input logic cwr, input logic [4:0] cadr,
                             input logic [7:0] cdin, input logic dreq, input logic [4:0] dadr,
                             input logic [7:0] ddin);
    mi = '{clr: clr, cwr: cwr, cadr: cadr, cdin: cdin, dreq: dreq, dadr: dadr, ddin: ddin};
  endfunction

  function automatic out_t mo(input logic wr, input logic [4:0] adr, input logic [7:0] din,
                              input logic stall, input logic ack, input logic busy,
                              input logic done);
    mo = '{wr: wr, adr: adr, din: din, stall: stall, ack: ack, busy: busy, done: done};
  endfunction

  task automatic drive(input in_t v);
    CLR_REQ    = v.clr;
    CPU_WR     = v.cwr;
    CPU_ADR    = v.cadr;
    CPU_DIN    = v.cdin;
    DBG_WR_REQ = v.dreq;
    DBG_ADR    = v.dadr;
    DBG_DIN    = v.ddin;
  endtask

  // Pops the oldest expectation and compares it with the DUT outputs as they are now.
  task automatic check_out(input string name);
    out_t act;
    out_t exp;
    act = {RF_WR, RF_ADRX, RF_DIN, CPU_STALL, DBG_WR_ACK, CLR_BUSY, CLR_DONE};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: no expectation queued, got %h", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_errors++;
        $display("FAIL %s: got wr=%b adr=%0d din=%h stall=%b ack=%b busy=%b done=%b, required wr=%b adr=%0d din=%h stall=%b ack=%b busy=%b done=%b",
                 name, act.wr, act.adr, act.din, act.stall, act.ack, act.busy, act.done,
                 exp.wr, exp.adr, exp.din, exp.stall, exp.ack, exp.busy, exp.done);
      end
    end
  endtask

  // One clock cycle: inputs are driven just after the rising edge and outputs are sampled on the
  // falling edge.
  task automatic step(input in_t i, input out_t o, input string name);
    drive(i);
    exp_q.push_back(o);
    @(negedge CLK);
    check_out(name);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Arbitration vectors, applied in order starting from IDLE with wait_cnt at 0.
    tbl[0]  = '{i: mi(0, 0, 0, 0, 0, 0, 0),
                o: mo(0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{i: mi(0, 1, 5, 8'hA5, 0, 0, 0),
                o: mo(1, 5, 8'hA5, 0, 0, 0, 0)};
    tbl[2]  = '{i: mi(0, 1, 5, 8'hA5, 1, 6, 8'h3C),
                o: mo(1, 5, 8'hA5, 0, 0, 0, 0)};
    tbl[3]  = tbl[2];
    tbl[4]  = tbl[2];
    tbl[5]  = tbl[2];
    tbl[6]  = '{i: mi(0, 1, 5, 8'hA5, 1, 6, 8'h3C),
                o: mo(1, 6, 8'h3C, 1, 1, 0, 0)};
    tbl[7]  = '{i: mi(0, 1, 5, 8'hA5, 0, 0, 0),
                o: mo(1, 5, 8'hA5, 0, 0, 0, 0)};
    tbl[8]  = '{i: mi(0, 0, 0, 0, 1, 7, 8'h42),
                o: mo(1, 7, 8'h42, 0, 1, 0, 0)};
    tbl[9]  = '{i: mi(0, 0, 0, 0, 1, 0, 8'hFF),
                o: R0Zero ? mo(0, 0, 0, 0, 1, 0, 0) : mo(1, 0, 8'hFF, 0, 1, 0, 0)};
    tbl[10] = '{i: mi(0, 1, 0, 8'h12, 0, 0, 0),
                o: R0Zero ? mo(0, 0, 0, 0, 0, 0, 0) : mo(1, 0, 8'h12, 0, 0, 0, 0)};
    tbl[11] = '{i: mi(1, 1, 9, 8'h33, 0, 0, 0),
                o: mo(1, 9, 8'h33, 0, 0, 0, 0)};

    RST_N = 1'b0;
    drive(mi(0, 0, 0, 0, 0, 0, 0));
    #12;
    exp_q.push_back(mo(0, 0, 0, 0, 0, 0, 0));
    check_out("reset_state");
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    for (int k = 0; k < 12; k++) begin
      step(tbl[k].i, tbl[k].o, $sformatf("vec%0d", k));
    end

    // Clear started by vec11. CLR_REQ stays high to show it is ignored, and the CPU is stalled.
    for (int a = 0; a < 32; a++) begin
      step(mi(1, 1, 3, 8'h11, 0, 0, 0), mo(1, 5'(a), 0, 1, 0, 1, 0),
           $sformatf("clear1_adr%0d", a));
    end
    step(mi(0, 1, 3, 8'h11, 0, 0, 0), mo(1, 3, 8'h11, 0, 0, 0, 1), "clear1_done_cpu");

    // Second clear with debug pending throughout; debug wins the first IDLE cycle.
    step(mi(1, 0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 0), "clear2_start");
    for (int a = 0; a < 32; a++) begin
      step(mi(0, 1, 3, 8'h11, 1, 8, 8'h5A), mo(1, 5'(a), 0, 1, 0, 1, 0),
           $sformatf("clear2_adr%0d", a));
    end
    step(mi(0, 1, 3, 8'h11, 1, 8, 8'h5A), mo(1, 8, 8'h5A, 1, 1, 0, 1), "clear2_dbg_force");
    step(mi(0, 1, 3, 8'h11, 0, 0, 0), mo(1, 3, 8'h11, 0, 0, 0, 0), "clear2_cpu_resume");

    // Reset while clr_adr is 10.
    step(mi(1, 0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 0), "clear3_start");
    for (int a = 0; a < 10; a++) begin
      step(mi(0, 0, 0, 0, 0, 0, 0), mo(1, 5'(a), 0, 0, 0, 1, 0),
           $sformatf("clear3_adr%0d", a));
    end
    exp_q.push_back(mo(1, 10, 0, 0, 0, 1, 0));
    #1;
    check_out("clear3_adr10");
    RST_N = 1'b0;
    exp_q.push_back(mo(0, 0, 0, 0, 0, 0, 0));
    #1;
    check_out("async_reset_mid_clear");
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    step(mi(0, 0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 0), "no_done_after_reset");
    step(mi(1, 0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0, 0), "clear4_start");
    step(mi(0, 0, 0, 0, 0, 0, 0), mo(1, 0, 0, 0, 0, 1, 0), "clear4_restart_adr0");
    step(mi(0, 0, 0, 0, 0, 0, 0), mo(1, 1, 0, 0, 0, 1, 0), "clear4_adr1");

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
